// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I+Zicsr instruction encoder feeding a small valid/ready FIFO.
module inst_encoder #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [47:0]              inst_flags,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [31:0]              imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     out_err,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_FIX} fmt_t;

  logic [5:0]  sel;
  logic        malformed;
  fmt_t        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fixed_word;
  logic [31:0] enc_word;

  // Index of the set flag; only meaningful when exactly one flag is set.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 48; i++) begin
      if (inst_flags[i]) sel = 6'(i);
    end
  end

  assign malformed = ($countones(inst_flags) != 1);

  always_comb begin
    fmt        = F_FIX;
    opc        = 7'h00;
    f3         = 3'd0;
    f7         = 7'h00;
    fixed_word = 32'h0000_0000;
    case (sel)
      6'd0:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd0; end
      6'd1:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd5; end
      6'd2:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd7; end
      6'd3:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd4; end
      6'd4:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd6; end
      6'd5:  begin fmt = F_B;  opc = 7'h63; f3 = 3'd1; end
      6'd6:  begin fmt = F_I;  opc = 7'h67; f3 = 3'd0; end
      6'd7:  begin fmt = F_J;  opc = 7'h6F; end
      6'd8:  begin fmt = F_U;  opc = 7'h17; end
      6'd9:  begin fmt = F_I;  opc = 7'h13; f3 = 3'd0; end
      6'd10: begin fmt = F_I;  opc = 7'h13; f3 = 3'd7; end
      6'd11: begin fmt = F_I;  opc = 7'h13; f3 = 3'd6; end
      6'd12: begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
      6'd13: begin fmt = F_I;  opc = 7'h13; f3 = 3'd2; end
      6'd14: begin fmt = F_I;  opc = 7'h13; f3 = 3'd3; end
      6'd15: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
      6'd16: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
      6'd17: begin fmt = F_I;  opc = 7'h13; f3 = 3'd4; end
      6'd18: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; end
      6'd19: begin fmt = F_R;  opc = 7'h33; f3 = 3'd7; end
      6'd20: begin fmt = F_R;  opc = 7'h33; f3 = 3'd6; end
      6'd21: begin fmt = F_R;  opc = 7'h33; f3 = 3'd1; end
      6'd22: begin fmt = F_R;  opc = 7'h33; f3 = 3'd2; end
      6'd23: begin fmt = F_R;  opc = 7'h33; f3 = 3'd3; end
      6'd24: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
      6'd25: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; end
      6'd26: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
      6'd27: begin fmt = F_R;  opc = 7'h33; f3 = 3'd4; end
      6'd28: begin fmt = F_U;  opc = 7'h37; end
      6'd29: begin fmt = F_I;  opc = 7'h03; f3 = 3'd0; end
      6'd30: begin fmt = F_I;  opc = 7'h03; f3 = 3'd4; end
      6'd31: begin fmt = F_I;  opc = 7'h03; f3 = 3'd1; end
      6'd32: begin fmt = F_I;  opc = 7'h03; f3 = 3'd5; end
      6'd33: begin fmt = F_I;  opc = 7'h03; f3 = 3'd2; end
      6'd34: begin fmt = F_S;  opc = 7'h23; f3 = 3'd0; end
      6'd35: begin fmt = F_S;  opc = 7'h23; f3 = 3'd1; end
      6'd36: begin fmt = F_S;  opc = 7'h23; f3 = 3'd2; end
      // CSR forms share the I layout: csr address in [31:20], rs1 or uimm in [19:15].
      6'd37: begin fmt = F_I;  opc = 7'h73; f3 = 3'd3; end
      6'd38: begin fmt = F_I;  opc = 7'h73; f3 = 3'd7; end
      6'd39: begin fmt = F_I;  opc = 7'h73; f3 = 3'd2; end
      6'd40: begin fmt = F_I;  opc = 7'h73; f3 = 3'd6; end
      6'd41: begin fmt = F_I;  opc = 7'h73; f3 = 3'd1; end
      6'd42: begin fmt = F_I;  opc = 7'h73; f3 = 3'd5; end
      6'd43: fixed_word = 32'h0010_0073;
      6'd44: fixed_word = 32'h0000_0073;
      6'd45: fixed_word = 32'h3020_0073;
      6'd46: fixed_word = 32'h1020_0073;
      6'd47: fixed_word = 32'h1050_0073;
      default: fixed_word = 32'h0000_0000;
    endcase
  end

  always_comb begin
    enc_word = 32'h0000_0000;
    case (fmt)
      F_R:   enc_word = {f7, rs2, rs1, f3, rd, opc};
      F_I:   enc_word = {imm[11:0], rs1, f3, rd, opc};
      F_SH:  enc_word = {f7, imm[4:0], rs1, f3, rd, opc};
      F_S:   enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      F_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      F_U:   enc_word = {imm[31:12], rd, opc};
      F_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      F_FIX: enc_word = fixed_word;
      default: enc_word = 32'h0000_0000;
    endcase
    if (malformed) enc_word = 32'h0000_0000;
  end

  logic [31:0]   mem_inst [DEPTH];
  logic          mem_err  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = in_valid && !full;
  assign pop   = out_valid && out_ready;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;
  assign out_inst  = mem_inst[rd_ptr[AW-1:0]];
  assign out_err   = mem_err[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_count <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= 32'h0000_0000;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_inst[wr_ptr[AW-1:0]] <= enc_word;
        mem_err[wr_ptr[AW-1:0]]  <= malformed;
        wr_ptr                   <= wr_ptr + PW'(1);
        if (malformed && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;

  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [47:0]   inst_flags = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [7:0]    err_count;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] mq[$];
  int mcnt = 0;

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_flags(inst_flags), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word built from the ISA field layout with plain arithmetic on the instruction index.
  function automatic logic [31:0] model_word(input int k, input logic [4:0] d5, input logic [4:0] s15,
                                             input logic [4:0] s25, input logic [31:0] im);
    int unsigned d, s1, s2, v, opc, f3, f7, w, hi, lo, jf;
    byte fmt;
    d = d5; s1 = s15; s2 = s25; v = im; opc = 0; f3 = 0; f7 = 0; w = 0; fmt = "R";
    if (k <= 5) begin
      fmt = "B"; opc = 'h63;
      case (k) 0: f3 = 0; 1: f3 = 5; 2: f3 = 7; 3: f3 = 4; 4: f3 = 6; default: f3 = 1; endcase
    end else if (k == 6) begin fmt = "I"; opc = 'h67; end
    else if (k == 7) begin fmt = "J"; opc = 'h6F; end
    else if (k == 8) begin fmt = "U"; opc = 'h17; end
    else if (k <= 17) begin
      fmt = "I"; opc = 'h13;
      case (k)
        9: f3 = 0; 10: f3 = 7; 11: f3 = 6; 12: begin f3 = 1; fmt = "H"; end
        13: f3 = 2; 14: f3 = 3; 15: begin f3 = 5; f7 = 32; fmt = "H"; end
        16: begin f3 = 5; fmt = "H"; end
        default: f3 = 4;
      endcase
    end else if (k <= 27) begin
      opc = 'h33;
      case (k)
        18: f3 = 0; 19: f3 = 7; 20: f3 = 6; 21: f3 = 1; 22: f3 = 2; 23: f3 = 3;
        24: begin f3 = 5; f7 = 32; end 25: f3 = 5; 26: begin f3 = 0; f7 = 32; end
        default: f3 = 4;
      endcase
    end else if (k == 28) begin fmt = "U"; opc = 'h37; end
    else if (k <= 33) begin
      fmt = "I"; opc = 3;
      case (k) 29: f3 = 0; 30: f3 = 4; 31: f3 = 1; 32: f3 = 5; default: f3 = 2; endcase
    end else if (k <= 36) begin fmt = "S"; opc = 'h23; f3 = k - 34; end
    else if (k <= 42) begin
      fmt = "I"; opc = 'h73;
      case (k) 37: f3 = 3; 38: f3 = 7; 39: f3 = 2; 40: f3 = 6; 41: f3 = 1; default: f3 = 5; endcase
    end else begin
      case (k)
        43: w = 'h00100073; 44: w = 'h00000073; 45: w = 'h30200073;
        46: w = 'h10200073; default: w = 'h10500073;
      endcase
      return w;
    end
    case (fmt)
      "R": w = opc + (d << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (f7 << 25);
      "I": w = opc + (d << 7) + (f3 << 12) + (s1 << 15) + ((v & 'hFFF) << 20);
      "H": w = opc + (d << 7) + (f3 << 12) + (s1 << 15) + ((v & 31) << 20) + (f7 << 25);
      "S": w = opc + ((v & 31) << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (((v >> 5) & 127) << 25);
      "B": begin
        hi = ((v >> 12) & 1) * 64 + ((v >> 5) & 63);
        lo = ((v >> 1) & 15) * 2 + ((v >> 11) & 1);
        w = opc + (lo << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (hi << 25);
      end
      "U": w = opc + (d << 7) + (v & 'hFFFFF000);
      default: begin
        jf = (((v >> 20) & 1) << 19) + (((v >> 1) & 1023) << 9) + (((v >> 11) & 1) << 8) + ((v >> 12) & 255);
        w = opc + (d << 7) + (jf << 12);
      end
    endcase
    return w;
  endfunction

  function automatic logic [32:0] ref_entry();
    if ($countones(inst_flags) != 1) return {1'b1, 32'h0};
    for (int k = 0; k < 48; k++)
      if (inst_flags[k]) return {1'b0, model_word(k, rd, rs1, rs2, imm)};
    return '0;
  endfunction

  task automatic check_state();
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("out_valid", out_valid, mq.size() != 0);
    check("level", level, mq.size());
    check("err_count", err_count, mcnt);
    if (mq.size() != 0) begin
      check("out_inst", out_inst, mq[0][31:0]);
      check("out_err", out_err, mq[0][32]);
    end
  endtask

  task automatic step();
    bit do_push, do_pop;
    logic [32:0] e;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() != 0);
    e = ref_entry();
    @(posedge clk); #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(e);
      if (e[32] && mcnt < 255) mcnt++;
    end
    check_state();
  endtask

  task automatic set_req(input int k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
    inst_flags = 48'd1 << k; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic send(input string tag, input int k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic [31:0] exp);
    set_req(k, d, s1, s2, im);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check(tag, {out_err, out_inst}, {1'b0, exp});
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
  endtask

  initial begin
    logic [63:0] r;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_err_count", err_count, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_err", out_err, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    send("addi", 9, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
    send("sub", 26, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);
    send("beq", 0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE208EE3);
    send("jal", 7, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF);
    send("lui", 28, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7);
    send("csrrw", 41, 5'd5, 5'd6, 5'd0, 32'h300, 32'h300312F3);
    send("ecall", 44, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 32'h00000073);
    send("mret", 45, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 32'h30200073);

    out_ready = 1'b0; in_valid = 1'b1;
    inst_flags = (48'd1 << 18) | (48'd1 << 26);
    step();
    inst_flags = '0;
    step();
    in_valid = 1'b0;
    check("bad_pair_level", level, 2);
    check("bad_pair_head", {out_err, out_inst}, {1'b1, 32'h0});
    check("bad_pair_count", err_count, 2);
    out_ready = 1'b1;
    step();
    check("bad_pair_second", {out_err, out_inst}, {1'b1, 32'h0});
    drain();

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        r = {$urandom, $urandom};
        inst_flags = r[47:0];
      end else begin
        inst_flags = 48'd1 << $urandom_range(0, 47);
      end
      step();
    end
    drain();

    out_ready = 1'b0; in_valid = 1'b1;
    set_req(9, 5'd1, 5'd2, 5'd0, 32'd1); step();
    set_req(18, 5'd3, 5'd4, 5'd5, 32'd0); step();
    set_req(34, 5'd0, 5'd6, 5'd7, 32'h7FF); step();
    check("bp_in_ready", in_ready, 0);
    check("bp_level", level, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    drain();

    in_valid = 1'b1; out_ready = 1'b1; inst_flags = '0;
    for (int i = 0; i < 300; i++) step();
    check("sat_count", err_count, 255);
    drain();

    out_ready = 1'b0; in_valid = 1'b1;
    set_req(19, 5'd9, 5'd10, 5'd11, 32'd0); step();
    set_req(21, 5'd12, 5'd13, 5'd14, 32'd0); step();
    in_valid = 1'b0;
    check("pre_rst_level", level, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    mq.delete(); mcnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    check_state();
    send("post_rst_addi", 9, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
    send("post_rst_srai", 15, 5'd2, 5'd3, 5'd31, 32'hFFFFFFE7, 32'h4071D113);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
